// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add frame driver.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  // Bit-counter width; a 1-bit frame still needs a 1-bit counter.
  function automatic int unsigned sa_cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Combined PISO/SIPO register: parallel load, right shift with serial input at the MSB.
module serial_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] par_in,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic         ser_out,
  output logic [W-1:0] par_out
);

  logic [W-1:0] q;
  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_single
      assign shifted = ser_in;
    end else begin : g_multi
      assign shifted = {ser_in, q[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= par_in;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

  assign ser_out = q[0];
  assign par_out = q;

endmodule

// File: rtl/serial_add_frame_driver.sv
// Initiator side of the bit-serial add interface: serializes an operand pair LSB-first
// and collects the returned sum bits into a parallel result word.
module serial_add_frame_driver
  import serial_add_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         ser_stall,
  output logic         ser_vld,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_last,
  input  logic         ser_sum,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum
);

  localparam int unsigned CNT_W = sa_cnt_w(W);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(W - 1);

  sa_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             issue;
  logic             last_bit;
  logic             a_lsb;
  logic             b_lsb;
  logic             sum_lsb;
  logic [W-1:0]     a_par;
  logic [W-1:0]     b_par;
  logic [W-1:0]     sum_par;

  assign load     = (state == IDLE) && in_valid;
  assign issue    = (state == SHIFT) && !ser_stall;
  assign last_bit = (cnt == LastCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (issue) begin
            cnt <= cnt + 1'b1;
            if (last_bit) state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  serial_shift_reg #(.W(W)) u_sr_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .par_in   (in_a),
    .shift_en (issue),
    .ser_in   (1'b0),
    .ser_out  (a_lsb),
    .par_out  (a_par)
  );

  serial_shift_reg #(.W(W)) u_sr_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .par_in   (in_b),
    .shift_en (issue),
    .ser_in   (1'b0),
    .ser_out  (b_lsb),
    .par_out  (b_par)
  );

  // Sum bits enter at the MSB so after W shifts bit i holds slot i.
  serial_shift_reg #(.W(W)) u_sr_sum (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .par_in   ({W{1'b0}}),
    .shift_en (issue),
    .ser_in   (ser_sum),
    .ser_out  (sum_lsb),
    .par_out  (sum_par)
  );

  assign in_ready  = (state == IDLE);
  assign ser_vld   = issue;
  assign ser_a     = issue & a_lsb;
  assign ser_b     = issue & b_lsb;
  assign ser_last  = issue & last_bit;
  assign res_valid = (state == DONE);
  assign res_sum   = sum_par;

endmodule

// File: tb/tb_serial_add_frame_driver.sv
// Self-checking bench: DUT paired with a golden bit-serial adder, table vectors,
// hand-written corner sequences and randomized frames against an arithmetic model.
module tb_serial_add_frame_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         ser_stall = 1'b0;
  logic         ser_vld, ser_a, ser_b, ser_last, ser_sum;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [0:0]   in_a1 = '0;
  logic [0:0]   in_b1 = '0;
  logic         ser_stall1 = 1'b0;
  logic         ser_vld1, ser_a1, ser_b1, ser_last1, ser_sum1;
  logic         res_valid1;
  logic         res_ready1 = 1'b0;
  logic [0:0]   res_sum1;

  logic carry, carry1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_frame_driver #(.W(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .ser_stall(ser_stall), .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b),
    .ser_last(ser_last), .ser_sum(ser_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum)
  );

  serial_add_frame_driver #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1),
    .in_b(in_b1), .ser_stall(ser_stall1), .ser_vld(ser_vld1), .ser_a(ser_a1),
    .ser_b(ser_b1), .ser_last(ser_last1), .ser_sum(ser_sum1), .res_valid(res_valid1),
    .res_ready(res_ready1), .res_sum(res_sum1)
  );

  // Golden bit-serial adder: carry cleared after the framed MSB.
  assign ser_sum  = ser_a ^ ser_b ^ carry;
  assign ser_sum1 = ser_a1 ^ ser_b1 ^ carry1;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry  <= 1'b0;
      carry1 <= 1'b0;
    end else begin
      if (ser_vld)
        carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (ser_a & carry) | (ser_b & carry));
      if (ser_vld1)
        carry1 <= ser_last1 ? 1'b0 :
                  ((ser_a1 & ser_b1) | (ser_a1 & carry1) | (ser_b1 & carry1));
    end
  end

  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = (int'(a) + int'(b)) % 256;
    return s[W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input int stall_pct,
                           input int hold, input logic [W-1:0] exp, input string tag);
    int bits;
    int lasts;
    int stalls;
    bit done;
    bits = 0; lasts = 0; stalls = 0; done = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b0; ser_stall = 1'b0;
    #1 check({tag, "_in_ready_idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    for (int k = 1; k <= 200 && !done; k++) begin
      ser_stall = ($urandom_range(99) < stall_pct);
      #1;
      if (res_valid) begin
        done = 1;
        ser_stall = 1'b0;
        check({tag, "_latency"}, k, W + 1 + stalls);
        check({tag, "_res_sum"}, res_sum, exp);
        check({tag, "_bit_count"}, bits, W);
        check({tag, "_last_count"}, lasts, 1);
        check({tag, "_in_ready_done"}, in_ready, 0);
        check({tag, "_vld_done"}, ser_vld, 0);
        for (int h = 0; h < hold; h++) begin
          in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
          @(negedge clk);
          #1;
          check({tag, "_hold_valid"}, res_valid, 1);
          check({tag, "_hold_sum"}, res_sum, exp);
          check({tag, "_hold_in_ready"}, in_ready, 0);
          check({tag, "_hold_vld"}, ser_vld, 0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1 check({tag, "_back_idle"}, in_ready, 1);
      end else begin
        check({tag, "_in_ready_busy"}, in_ready, 0);
        if (ser_vld) begin
          if (bits < W) begin
            check({tag, "_ser_a"}, ser_a, a[bits]);
            check({tag, "_ser_b"}, ser_b, b[bits]);
          end
          if (stalls == 0) check({tag, "_bit_cycle"}, k, bits + 1);
          check({tag, "_ser_last"}, ser_last, (bits == W - 1) ? 1 : 0);
          if (ser_last) lasts++;
          bits++;
        end else begin
          stalls++;
          check({tag, "_stall_quiet"}, {ser_a, ser_b, ser_last}, 0);
        end
        @(negedge clk);
      end
    end
    ser_stall = 1'b0;
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           stall_pct;
    int           hold;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 8'h35, b: 8'h4A, stall_pct: 0,  hold: 0,  exp: 8'h7F};
    vecs[1] = '{a: 8'hFF, b: 8'h01, stall_pct: 0,  hold: 0,  exp: 8'h00};
    vecs[2] = '{a: 8'h80, b: 8'h80, stall_pct: 0,  hold: 0,  exp: 8'h00};
    vecs[3] = '{a: 8'h01, b: 8'h00, stall_pct: 0,  hold: 0,  exp: 8'h01};
    vecs[4] = '{a: 8'h5A, b: 8'h3C, stall_pct: 50, hold: 0,  exp: 8'h96};
    vecs[5] = '{a: 8'h5A, b: 8'h3C, stall_pct: 0,  hold: 10, exp: 8'h96};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_ser", {ser_vld, ser_a, ser_b, ser_last}, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_sum", res_sum, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i].a, vecs[i].b, vecs[i].stall_pct,
                                          vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset while the 4th bit is on the wire.
    @(negedge clk);
    in_a = 8'h77; in_b = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("rst_mid_vld_before", ser_vld, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_vld", ser_vld, 0);
    check("rst_mid_last", ser_last, 0);
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    #1 check("rst_mid_quiet", ser_vld, 0);
    run_frame(8'h12, 8'h34, 0, 0, 8'h46, "after_rst");

    // One-bit instance: single SHIFT cycle carrying ser_last.
    @(negedge clk);
    in_a1 = 1'b1; in_b1 = 1'b1; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    check("w1_vld", ser_vld1, 1);
    check("w1_last", ser_last1, 1);
    check("w1_bits", {ser_a1, ser_b1}, 2'b11);
    @(negedge clk);
    #1;
    check("w1_vld_after", ser_vld1, 0);
    check("w1_res_valid", res_valid1, 1);
    check("w1_res_sum", res_sum1, 0);
    res_ready1 = 1'b1;
    @(negedge clk);
    res_ready1 = 1'b0;
    #1 check("w1_idle", in_ready1, 1);

    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int sp;
      ra = W'($urandom);
      rb = W'($urandom);
      sp = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 30 : 50);
      run_frame(ra, rb, sp, int'($urandom_range(2)), ref_add(ra, rb), $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
